// File: rtl/dma_engine.sv
// Single-channel memory-to-memory AXI DMA master: one beat at a time, read -> write -> response.
// Descriptor latched on trigger; address steps by DATA_W/8 per beat when enabled.
module dma_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    input  logic [LEN_W-1:0]    length,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic                src_inc,
    input  logic                dst_inc,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [LEN_W-1:0]    beats_done,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP
);

    // state     | meaning
    // S_IDLE    | waiting for trigger
    // S_RD_ADDR | AR channel valid, current source address
    // S_RD_DATA | accepting one read beat
    // S_WR      | AW and W valid, each dropping on its own handshake
    // S_WR_RESP | accepting the write response
    // S_FINISH  | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    state_t state, state_nxt;

    logic [LEN_W-1:0] remaining;
    logic src_inc_q, dst_inc_q;
    logic start, ar_hs, r_hs, aw_ok, w_ok, b_hs, last_beat;
    logic arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt, busy_nxt, done_nxt;

    assign start     = (state == S_IDLE) && trigger;
    assign ar_hs     = ARVALID && ARREADY;
    assign r_hs      = RVALID && RREADY;
    assign aw_ok     = !AWVALID || AWREADY;
    assign w_ok      = !WVALID || WREADY;
    assign b_hs      = BVALID && BREADY;
    assign last_beat = (remaining == LEN_W'(1));
    assign WSTRB     = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (trigger) state_nxt = (length != '0) ? S_RD_ADDR : S_FINISH;
            S_RD_ADDR: if (ar_hs) state_nxt = S_RD_DATA;
            S_RD_DATA: if (r_hs) state_nxt = (RRESP != 2'b00) ? S_FINISH : S_WR;
            S_WR:      if (aw_ok && w_ok) state_nxt = S_WR_RESP;
            S_WR_RESP: if (b_hs) state_nxt = ((BRESP != 2'b00) || last_beat) ? S_FINISH : S_RD_ADDR;
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from state_nxt so every one leaves a flop.
    always_comb begin
        arvalid_nxt = (state_nxt == S_RD_ADDR);
        rready_nxt  = (state_nxt == S_RD_DATA);
        bready_nxt  = (state_nxt == S_WR_RESP);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_FINISH);
        awvalid_nxt = (state_nxt == S_WR) && ((state != S_WR) || (AWVALID && !AWREADY));
        wvalid_nxt  = (state_nxt == S_WR) && ((state != S_WR) || (WVALID && !WREADY));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            AWVALID    <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            beats_done <= '0;
            remaining  <= '0;
            ARADDR     <= '0;
            AWADDR     <= '0;
            WDATA      <= '0;
            src_inc_q  <= 1'b0;
            dst_inc_q  <= 1'b0;
        end else begin
            ARVALID <= arvalid_nxt;
            RREADY  <= rready_nxt;
            AWVALID <= awvalid_nxt;
            WVALID  <= wvalid_nxt;
            BREADY  <= bready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            if (start) begin
                remaining  <= length;
                ARADDR     <= src_addr;
                AWADDR     <= dst_addr;
                src_inc_q  <= src_inc;
                dst_inc_q  <= dst_inc;
                error      <= 1'b0;
                beats_done <= '0;
            end
            if ((state == S_RD_DATA) && r_hs) begin
                if (RRESP != 2'b00) error <= 1'b1;
                else                WDATA <= RDATA;
            end
            // Addresses only move after the B handshake, while no valid is up.
            if ((state == S_WR_RESP) && b_hs) begin
                if (BRESP != 2'b00) begin
                    error <= 1'b1;
                end else begin
                    beats_done <= beats_done + LEN_W'(1);
                    remaining  <= remaining - LEN_W'(1);
                    if (src_inc_q) ARADDR <= ARADDR + STEP;
                    if (dst_inc_q) AWADDR <= AWADDR + STEP;
                end
            end
        end
    end

endmodule
